// File: rtl/acq_sample_writer.sv
// Turns FD read-data pulse intervals into bytes (bit7 = index marker) and
// writes them through a small FIFO to the sample SRAM request/ack port.
module acq_sample_writer #(
  parameter int ADDR_WIDTH = 19,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK_MASTER,
  input  logic                  RESET_N,
  input  logic                  ACQUIRING,
  input  logic                  ABORT,
  input  logic                  FD_RDDATA_IN,
  input  logic                  FD_INDEX_IN,
  input  logic [1:0]            TIMEBASE_SEL,
  input  logic                  ADDR_LOAD,
  input  logic [ADDR_WIDTH-1:0] ADDR_IN,
  output logic                  SR_WR_REQ,
  input  logic                  SR_WR_ACK,
  output logic [ADDR_WIDTH-1:0] SR_ADDR,
  output logic [7:0]            SR_DATA,
  output logic                  SR_R_FULL,
  output logic                  OVERRUN,
  output logic                  BUSY
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [0:0] {W_IDLE = 1'b0, W_REQ = 1'b1} wr_state_t;

  logic            rd_meta_r, rd_sync_r, rd_prev_r, rd_pulse_r;
  logic            ix_meta_r, ix_sync_r, ix_prev_r, ix_pulse_r;
  logic [2:0]      presc_r;
  logic [2:0]      presc_mask_s;
  logic            tick_s;
  logic [6:0]      cnt_r;
  logic            idx_r;
  logic            acq_run_s, carry_s, emit_s;
  logic [7:0]      emit_byte_s;
  logic [7:0]      fifo_mem_r [FIFO_DEPTH];
  logic [PW:0]     wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic            fifo_empty_s, fifo_full_s, push_s, pop_s, overflow_s;
  logic            load_ok_s;
  wr_state_t       state_r, state_nxt_s;

  // Two-flop synchronisers and registered rising-edge pulses for both FDD inputs
  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_meta_r  <= 1'b0;
      rd_sync_r  <= 1'b0;
      rd_prev_r  <= 1'b0;
      rd_pulse_r <= 1'b0;
      ix_meta_r  <= 1'b0;
      ix_sync_r  <= 1'b0;
      ix_prev_r  <= 1'b0;
      ix_pulse_r <= 1'b0;
    end else begin
      rd_meta_r  <= FD_RDDATA_IN;
      rd_sync_r  <= rd_meta_r;
      rd_prev_r  <= rd_sync_r;
      rd_pulse_r <= rd_sync_r & ~rd_prev_r;
      ix_meta_r  <= FD_INDEX_IN;
      ix_sync_r  <= ix_meta_r;
      ix_prev_r  <= ix_sync_r;
      ix_pulse_r <= ix_sync_r & ~ix_prev_r;
    end
  end

  // Prescaler mask selection
  always_comb begin
    presc_mask_s = 3'b000;
    case (TIMEBASE_SEL)
      2'd0:    presc_mask_s = 3'b000;
      2'd1:    presc_mask_s = 3'b001;
      2'd2:    presc_mask_s = 3'b011;
      2'd3:    presc_mask_s = 3'b111;
      default: presc_mask_s = 3'b000;
    endcase
  end

  assign tick_s = ((presc_r & presc_mask_s) == 3'b000);

  // Prescaler restarts with each acquisition so the first cycle always ticks
  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_r <= 3'b000;
    end else if (!ACQUIRING) begin
      presc_r <= 3'b000;
    end else begin
      presc_r <= presc_r + 3'd1;
    end
  end

  // Byte emission: a data pulse wins over a counter carry
  always_comb begin
    acq_run_s   = ACQUIRING & ~ABORT;
    carry_s     = acq_run_s & ~rd_pulse_r & tick_s & (cnt_r == 7'h7F);
    emit_s      = (acq_run_s & rd_pulse_r) | carry_s;
    emit_byte_s = {idx_r, cnt_r};
  end

  // Interval counter and index-pending flag
  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_r <= 7'd0;
      idx_r <= 1'b0;
    end else if (!acq_run_s) begin
      cnt_r <= 7'd0;
      idx_r <= 1'b0;
    end else begin
      if (emit_s) begin
        cnt_r <= 7'd0;
      end else if (tick_s) begin
        cnt_r <= cnt_r + 7'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      // An index coinciding with an emission marks the following byte
      if (ix_pulse_r) begin
        idx_r <= 1'b1;
      end else if (emit_s) begin
        idx_r <= 1'b0;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // FIFO status, push/drop decision and next pointers
  always_comb begin
    fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    fifo_full_s  = (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]) && (wr_ptr_r[PW] != rd_ptr_r[PW]);
    push_s       = emit_s & ~SR_R_FULL & (~fifo_full_s | pop_s);
    overflow_s   = emit_s & ~SR_R_FULL & fifo_full_s & ~pop_s;
    if (ABORT) begin
      wr_ptr_nxt_s = {(PW+1){1'b0}};
      rd_ptr_nxt_s = {(PW+1){1'b0}};
    end else begin
      wr_ptr_nxt_s = push_s ? wr_ptr_r + {{PW{1'b0}}, 1'b1} : wr_ptr_r;
      rd_ptr_nxt_s = pop_s  ? rd_ptr_r + {{PW{1'b0}}, 1'b1} : rd_ptr_r;
    end
  end

  // FIFO storage and pointers
  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r <= {(PW+1){1'b0}};
      rd_ptr_r <= {(PW+1){1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= 8'h00;
      end
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      if (push_s) begin
        fifo_mem_r[wr_ptr_r[PW-1:0]] <= emit_byte_s;
      end
    end
  end

  // Write-port next state; ABORT stops new requests but not one in flight
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    case (state_r)
      W_IDLE: begin
        if (!fifo_empty_s && !SR_R_FULL && !ABORT) begin
          pop_s       = 1'b1;
          state_nxt_s = W_REQ;
        end else begin
          state_nxt_s = W_IDLE;
        end
      end
      W_REQ: begin
        if (SR_WR_ACK) begin
          state_nxt_s = W_IDLE;
        end else begin
          state_nxt_s = W_REQ;
        end
      end
      default: state_nxt_s = W_IDLE;
    endcase
  end

  assign load_ok_s = ADDR_LOAD && (state_r == W_IDLE);

  // Write-port state and registered SRAM-side outputs
  always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= W_IDLE;
      SR_WR_REQ <= 1'b0;
      SR_DATA   <= 8'h00;
      SR_ADDR   <= {ADDR_WIDTH{1'b0}};
      SR_R_FULL <= 1'b0;
      OVERRUN   <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (pop_s) begin
        SR_DATA   <= fifo_mem_r[rd_ptr_r[PW-1:0]];
        SR_WR_REQ <= 1'b1;
      end else if ((state_r == W_REQ) && SR_WR_ACK) begin
        SR_WR_REQ <= 1'b0;
      end
      // Address saturates at all-ones; the last location sets the sticky full flag
      if (load_ok_s) begin
        SR_ADDR   <= ADDR_IN;
        SR_R_FULL <= 1'b0;
      end else if ((state_r == W_REQ) && SR_WR_ACK) begin
        if (&SR_ADDR) begin
          SR_R_FULL <= 1'b1;
        end else begin
          SR_ADDR <= SR_ADDR + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      if (overflow_s) begin
        OVERRUN <= 1'b1;
      end else if (load_ok_s) begin
        OVERRUN <= 1'b0;
      end
      BUSY <= (wr_ptr_nxt_s != rd_ptr_nxt_s) || (state_nxt_s == W_REQ);
    end
  end

endmodule

// File: tb/tb_acq_sample_writer.sv
// Directed bench for acq_sample_writer: expected SRAM writes are queued as
// pulses are driven and matched against writes captured by an ACK responder.
module tb_acq_sample_writer;
  localparam int AW = 19;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          acquiring, abort_s, fd_rd, fd_ix, addr_load;
  logic [1:0]    tb_sel;
  logic [AW-1:0] addr_in;
  logic          sr_wr_req, sr_r_full, overrun, busy;
  logic          sr_wr_ack = 1'b0;
  logic [AW-1:0] sr_addr;
  logic [7:0]    sr_data;
  logic          ack_en;

  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] obs_q[$];
  logic [AW-1:0] next_addr;
  int            n_assert = 0;
  int            n_fail = 0;

  acq_sample_writer #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .CLK_MASTER(clk), .RESET_N(rst_n), .ACQUIRING(acquiring), .ABORT(abort_s),
    .FD_RDDATA_IN(fd_rd), .FD_INDEX_IN(fd_ix), .TIMEBASE_SEL(tb_sel),
    .ADDR_LOAD(addr_load), .ADDR_IN(addr_in), .SR_WR_REQ(sr_wr_req),
    .SR_WR_ACK(sr_wr_ack), .SR_ADDR(sr_addr), .SR_DATA(sr_data),
    .SR_R_FULL(sr_r_full), .OVERRUN(overrun), .BUSY(busy)
  );

  always #5 clk = ~clk;

  // SRAM model: one-cycle ACK per request, recording address and data
  always @(posedge clk) begin
    #1;
    if (ack_en && sr_wr_req && !sr_wr_ack) begin
      sr_wr_ack = 1'b1;
      obs_q.push_back({sr_addr, sr_data});
    end else begin
      sr_wr_ack = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic exp_push(input logic [7:0] b);
    exp_q.push_back({next_addr, b});
    next_addr = next_addr + 19'd1;
  endtask

  // Pulse raised now reaches the counter 3 cycles later; exp_byte < 0 means no write expected
  task automatic pulse_rd(input int exp_byte);
    logic [7:0] b;
    b = exp_byte[7:0];
    if (exp_byte >= 0) exp_push(b);
    fd_rd = 1'b1;
    step(1);
    fd_rd = 1'b0;
  endtask

  task automatic load_addr(input logic [AW-1:0] a);
    addr_in   = a;
    addr_load = 1'b1;
    step(1);
    addr_load = 1'b0;
    next_addr = a;
  endtask

  task automatic check_all(input string tag, input int budget);
    int waited;
    logic [31:0] e, o;
    waited = 0;
    while ((obs_q.size() < exp_q.size()) && (waited < budget)) begin
      step(1);
      waited++;
    end
    step(3);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while ((exp_q.size() > 0) && (obs_q.size() > 0)) begin
      e = {5'b0, exp_q.pop_front()};
      o = {5'b0, obs_q.pop_front()};
      chk(tag, o, e);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; acquiring = 1'b0; abort_s = 1'b0; fd_rd = 1'b0; fd_ix = 1'b0;
    addr_load = 1'b0; addr_in = '0; tb_sel = 2'd0; ack_en = 1'b1; next_addr = '0;
    step(3);
    chk("reset_outs", {1'b0, sr_wr_req, sr_r_full, overrun, busy, sr_data, sr_addr}, 32'h0);
    rst_n = 1'b1;
    step(2);
    load_addr(19'h0);

    // Pulses 21 cycles apart: 20 counted ticks (the pulse-cycle tick is discarded)
    acquiring = 1'b1;
    step(17);
    pulse_rd(8'h14);
    step(3);
    chk("fill_req_lo", sr_wr_req, 1'b1 ^ 1'b1);
    chk("fill_busy", busy, 1'b1);
    step(1);
    chk("fill_req_hi", {sr_wr_req, sr_data, 5'b0, sr_addr}, {1'b1, 8'h14, 5'b0, 19'h0});
    step(16);
    repeat (2) begin
      pulse_rd(8'h14);
      step(20);
    end
    acquiring = 1'b0;
    check_all("steady", 60);

    // Tick every 4 cycles: ticks at 0,4,..,36 before the pulse at cycle 40
    step(5);
    tb_sel = 2'd2;
    acquiring = 1'b1;
    step(37);
    pulse_rd(8'h0A);
    step(10);
    acquiring = 1'b0;
    tb_sel = 2'd0;
    check_all("tbsel2", 40);

    // 300 ticks: two carries consume 128 each, remainder 44
    step(5);
    exp_push(8'h7F);
    exp_push(8'h7F);
    acquiring = 1'b1;
    step(297);
    pulse_rd(8'h2C);
    step(10);
    acquiring = 1'b0;
    check_all("carry", 40);

    // Index mid-interval, then index coincident with a data pulse
    step(5);
    acquiring = 1'b1;
    step(5);
    fd_ix = 1'b1; step(1); fd_ix = 1'b0;
    step(11);
    pulse_rd(8'h94);
    step(20);
    pulse_rd(8'h14);
    step(20);
    fd_ix = 1'b1;
    pulse_rd(8'h14);
    fd_ix = 1'b0;
    step(20);
    pulse_rd(8'h94);
    step(10);
    acquiring = 1'b0;
    check_all("index", 60);

    // Last two addresses, then full; third byte discarded
    step(5);
    load_addr(19'h7FFFE);
    acquiring = 1'b1;
    step(17);
    pulse_rd(8'h14);
    step(20);
    pulse_rd(8'h14);
    step(20);
    pulse_rd(-1);
    step(10);
    acquiring = 1'b0;
    check_all("full", 40);
    chk("full_flag", {sr_r_full, 5'b0, sr_addr}, {1'b1, 5'b0, 19'h7FFFF});
    chk("full_busy", busy, 1'b0);
    load_addr(19'h00200);
    chk("load_clears_full", {sr_r_full, 5'b0, sr_addr}, {1'b0, 5'b0, 19'h00200});

    // ACK held: one byte in flight plus four buffered, sixth dropped
    ack_en = 1'b0;
    acquiring = 1'b1;
    step(17);
    pulse_rd(8'h14); step(10);
    pulse_rd(8'h0A); step(30);
    pulse_rd(8'h1E); step(40);
    pulse_rd(8'h28); step(50);
    pulse_rd(8'h32); step(60);
    pulse_rd(-1);    step(10);
    chk("ovr_flag", {overrun, busy, sr_wr_req, sr_data}, {1'b1, 1'b1, 1'b1, 8'h14});
    addr_in = 19'h00055; addr_load = 1'b1; step(1); addr_load = 1'b0;
    chk("load_in_req", {overrun, 5'b0, sr_addr}, {1'b1, 5'b0, 19'h00200});
    acquiring = 1'b0;
    ack_en = 1'b1;
    check_all("overrun", 60);
    chk("ovr_sticky", {overrun, busy}, {1'b1, 1'b0});

    // ABORT during W_REQ: in-flight write completes, buffered bytes flushed
    load_addr(19'h00300);
    chk("load_clears_ovr", overrun, 1'b0);
    ack_en = 1'b0;
    acquiring = 1'b1;
    step(17);
    pulse_rd(8'h14); step(10);
    pulse_rd(-1);    step(10);
    pulse_rd(-1);    step(6);
    abort_s = 1'b1;
    acquiring = 1'b0;
    step(2);
    chk("abort_busy_inflight", {busy, sr_wr_req}, {1'b1, 1'b1});
    ack_en = 1'b1;
    step(5);
    chk("abort_req_done", sr_wr_req, 1'b0);
    abort_s = 1'b0;
    step(3);
    check_all("abort", 20);
    chk("abort_idle", {busy, sr_wr_req}, {1'b0, 1'b0});

    // Asynchronous reset in the middle of a write
    ack_en = 1'b0;
    acquiring = 1'b1;
    step(17);
    pulse_rd(-1);
    step(5);
    chk("pre_reset_req", sr_wr_req, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {1'b0, sr_wr_req, sr_r_full, overrun, busy, sr_data, sr_addr}, 32'h0);
    acquiring = 1'b0;
    step(2);
    rst_n = 1'b1;
    ack_en = 1'b1;
    next_addr = '0;
    step(2);
    check_all("post_reset", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
